serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder built around the team's `full_add_behavorial` one-bit cell. It accepts two parallel operands plus a carry-in on a start strobe. It feeds one bit pair per clock, LSB first, through the full-adder cell, with the carry held in a flip-flop between bits. The finished sum and carry-out are presented in parallel with a one-cycle done pulse. It sits between a parallel operand source and any consumer that trades latency for a single-cell adder datapath.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  initial carry; captured when start is accepted
- busy  output  1  high while bits are being added (RUN)
- done  output  1  one-cycle pulse; sum/cout valid and updated
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered final carry, held until next completion

## Operation
- Datapath: shift registers sa, sb (WIDTH each), carry flop c, partial-sum shift register ps (WIDTH), bit counter cnt (log2 WIDTH bits, min 1).
- The full-adder instance takes a=sa[0], b=sb[0], cin=c. Its outputs s and cout drive the per-cycle update.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. On start=1: sa<=a, sb<=b, c<=cin, cnt<=0, go to RUN.
- RUN: busy=1. Each cycle:
  - sa and sb shift right by 1.
  - ps shifts right with s entering ps[WIDTH-1].
  - c<=cout, cnt<=cnt+1.
  - When cnt==WIDTH-1, the final bit is processed that cycle: sum<={s, ps[WIDTH-1:1]}, cout<=full-adder cout, go to DONE.
- DONE: busy=0, done=1 for exactly this cycle. On start=1, load new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- start in RUN is ignored; captured operands are not disturbed.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). It is unsigned, with no saturation. Wrap beyond WIDTH bits is reported only through cout.
- sum and cout change only on the DONE-entry edge or on reset. They are stable in IDLE, RUN and DONE otherwise.
- Reset (rst_n=0, any time, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, sa=sb=ps=0, c=0, cnt=0.
  - A reset mid-RUN aborts the operation. No done is produced and the partial result is discarded.

## Timing
- start accepted at rising edge k (state IDLE or DONE).
- busy=1 from edge k through edge k+WIDTH (WIDTH cycles).
- Edge k+WIDTH: sum/cout updated, done=1, busy=0. done falls at edge k+WIDTH+1.
- Latency start→done: WIDTH cycles. Back-to-back throughput: one result per WIDTH+1 cycles.
- A start held high continuously restarts at every DONE cycle. Operands are sampled at each acceptance edge.
- Reset deassertion: the first start can be accepted at the first rising edge with rst_n=1.
- done and busy are never high simultaneously.

## Test plan
- Reset: rst_n=0 for 2 cycles mid-idle -> busy=0, done=0, sum=8'h00, cout=0 immediately after rst_n falls.
- Basic add: WIDTH=8, a=8'h05, b=8'h03, cin=0, start 1 cycle -> busy high 8 cycles, done on 8th edge after acceptance, sum=8'h08, cout=0.
- Wrap-around: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: start a=8'h10, b=8'h20; at RUN cycle 3 pulse start with a=8'hAA, b=8'h55 -> single done, sum=8'h30, cout=0, no second operation.
- Reset mid-run: start a=8'h7F, b=8'h01; drop rst_n at RUN cycle 4 -> busy=0 at once, sum=0, cout=0, no done. Next start a=8'h02, b=8'h02 -> sum=8'h04 after 8 cycles.
- Back-to-back plus exhaustive sweep: start held high -> done every 9 cycles with correct results. Sweep all 2^17 (a,b,cin) for WIDTH=8 -> {cout,sum}=a+b+cin every time.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry held in a flop between bits.
// Operands load on start, are consumed LSB first, and the result is presented in parallel with a done pulse.
module full_add_behavorial (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ps;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             load;

  full_add_behavorial u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (c),
    .s    (fa_s),
    .cout (fa_co)
  );

  // start is only honoured outside RUN, so an in-flight add is never disturbed
  assign load = start && (state != RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      ps   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      ps  <= {fa_s, ps[WIDTH-1:1]};
      c   <= fa_co;
      cnt <= cnt + 1'b1;
      // the last bit goes straight into sum alongside the earlier partial bits
      if (cnt == LAST) begin
        sum  <= {fa_s, ps[WIDTH-1:1]};
        cout <= fa_co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // continuous invariants: busy/done exclusive, result stable outside completion
  logic [W:0] prev_res = '0;
  always @(negedge clk) begin
    if (busy && done) chk("busy_done_excl", {busy, done}, 2'b10);
    if (rst_n && !done && {cout, sum} !== prev_res) chk("result_stable", {cout, sum}, prev_res);
    prev_res = {cout, sum};
  end

  // one operation; optionally pulse start with junk operands during RUN cycle 3
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input bit glitch, input string tag);
    logic [W:0] exp;
    int cyc, nb;
    exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; nb = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (glitch && cyc == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, W);
    chk({tag, "_busy_cycles"}, nb, W);
    chk({tag, "_sum"}, sum, exp[W-1:0]);
    chk({tag, "_cout"}, cout, exp[W]);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    logic [W-1:0] pa, pb;
    logic         pc;
    logic [W:0]   exp;
    int cyc, seen_done;

    // reset state
    #1;
    chk("reset_init", {busy, done, cout, sum}, '0);
    #12 rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 0, "basic");
    run_op(8'hFF, 8'h01, 1'b0, 0, "wrap1");
    run_op(8'hFF, 8'hFF, 1'b1, 0, "wrap2");
    run_op(8'h00, 8'h00, 1'b0, 0, "zero");
    run_op(8'h00, 8'h00, 1'b1, 0, "cin_only");

    // reset in idle with a nonzero result held
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("idle_reset", {busy, done, cout, sum}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(8'h10, 8'h20, 1'b0, 1, "ign_start");

    // reset mid-run aborts without done
    @(negedge clk); start = 1'b1; a = 8'h7F; b = 8'h01; cin = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0; #1;
    chk("midrun_reset", {busy, done, cout, sum}, '0);
    seen_done = 0;
    repeat (10) begin @(posedge clk); #1; if (done) seen_done++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (done || busy) seen_done++; end
    chk("midrun_no_done", seen_done, 0);
    run_op(8'h02, 8'h02, 1'b0, 0, "after_abort");

    // random single ops
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, "rand");

    // back-to-back with start held high; junk on the inputs during RUN
    @(negedge clk);
    pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
    start = 1'b1; a = pa; b = pb; cin = pc;
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      exp = {1'b0, pa} + {1'b0, pb} + {{W{1'b0}}, pc};
      cyc = 0;
      while (!done && cyc < 40) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
      chk("b2b_latency", cyc, W);
      chk("b2b_result", {cout, sum}, exp);
      if (i < 399) begin
        case (i % 4)
          0:       begin pa = 8'hFF; pb = W'($urandom); end
          1:       begin pa = W'($urandom); pb = 8'h00; end
          default: begin pa = W'($urandom); pb = W'($urandom); end
        endcase
        pc = 1'($urandom);
        a = pa; b = pb; cin = pc;
        @(posedge clk); #1;
        chk("b2b_restart", {busy, done}, 2'b10);
      end else begin
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end_idle", {busy, done}, 2'b00);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
